part_74s299: RTL

Cycle-level model of the 74S299 8-bit universal shift/storage register with a shared parallel I/O bus, modelled as split in/out/enable ports. It sits beside the existing combinational gate models in the TTL part library. It is the storage-side counterpart to the AND-OR-INVERT logic that drives its mode and enable pins. The data-path and bus-interface boards instantiate it wherever a bidirectional shift/load register sits on a tristate bus.

---
 rtl/part_74s299.sv | 56 +++++
 1 files changed

// File: rtl/part_74s299.sv
// 74S299 8-bit universal shift/storage register, cycle-level model.
// The tristate I/O bus is split into IO_IN / IO_OUT / IO_OE.
module part_74s299 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             S0,
    input  logic             S1,
    input  logic             OE1_N,
    input  logic             OE2_N,
    input  logic             DS0,
    input  logic             DS7,
    input  logic [WIDTH-1:0] IO_IN,
    output logic [WIDTH-1:0] IO_OUT,
    output logic             IO_OE,
    output logic             Q0,
    output logic             Q7
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [1:0]       mode;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;

    assign mode = {S1, S0};

    always_comb begin
        r_d = r_q;
        unique case (mode)
            MODE_HOLD: r_d = r_q;
            MODE_SHR:  r_d = {r_q[WIDTH-2:0], DS0};
            MODE_SHL:  r_d = {DS7, r_q[WIDTH-1:1]};
            MODE_LOAD: r_d = IO_IN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // Load mode releases the bus so the incoming value can be captured.
    assign IO_OE  = ~OE1_N & ~OE2_N & ~(mode == MODE_LOAD);
    assign IO_OUT = r_q;
    assign Q0     = r_q[0];
    assign Q7     = r_q[WIDTH-1];

endmodule
